// File: rtl/param_register_bench_pkg.sv
// Shared definitions for the register bench: clear-engine states and
// indices of the hardwired registers.
package regbench_pkg;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_RUN,
        CLR_DONE
    } clr_state_t;

    localparam int unsigned REG_ZERO  = 0;
    localparam int unsigned REG_CONST = 1;

endpackage

// File: rtl/param_register_bench_if.sv
// Decode/writeback-facing bus of the register bench: read, write, reserve
// and clear requests towards the bench, data and status back.
interface param_register_bench_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREGS = 32
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [AW-1:0]    readAddy1;
    logic [AW-1:0]    readAddy2;
    logic [AW-1:0]    writeAddy;
    logic [WIDTH-1:0] writeData;
    logic             cu_writeReg;
    logic             cu_reserve;
    logic [AW-1:0]    reserveAddy;
    logic             clearReq;

    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] data3;
    logic             pend1;
    logic             pend2;
    logic             busy;
    logic             clearDone;
    logic             writeDropped;

    modport master (
        output readAddy1, readAddy2, writeAddy, writeData, cu_writeReg,
               cu_reserve, reserveAddy, clearReq,
        input  data1, data2, data3, pend1, pend2, busy, clearDone, writeDropped
    );

    modport slave (
        input  readAddy1, readAddy2, writeAddy, writeData, cu_writeReg,
               cu_reserve, reserveAddy, clearReq,
        output data1, data2, data3, pend1, pend2, busy, clearDone, writeDropped
    );

endinterface

// File: rtl/regbench_clear_fsm.sv
// Sequential clear engine: walks every register index once, then pulses
// clearDone for a single cycle. busy covers both the walk and the done cycle.
module regbench_clear_fsm
    import regbench_pkg::*;
#(
    parameter int unsigned NREGS = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clearReq,
    output logic                     busy,
    output logic                     clearDone,
    output logic                     clearing,
    output logic [$clog2(NREGS)-1:0] clearIdx
);
    localparam int unsigned AW = $clog2(NREGS);

    clr_state_t state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CLR_IDLE;
            clearIdx  <= '0;
            busy      <= 1'b0;
            clearDone <= 1'b0;
            clearing  <= 1'b0;
        end else begin
            clearDone <= 1'b0;
            unique case (state)
                CLR_IDLE: begin
                    if (clearReq) begin
                        state    <= CLR_RUN;
                        clearIdx <= '0;
                        busy     <= 1'b1;
                        clearing <= 1'b1;
                    end
                end
                CLR_RUN: begin
                    // NREGS is a power of two, so the last index is all ones
                    clearIdx <= clearIdx + AW'(1);
                    if (clearIdx == '1) begin
                        state     <= CLR_DONE;
                        clearing  <= 1'b0;
                        clearDone <= 1'b1;
                    end
                end
                CLR_DONE: begin
                    state <= CLR_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= CLR_IDLE;
                    busy     <= 1'b0;
                    clearing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/param_register_bench.sv
// NREGS x WIDTH register bench: three combinational read ports, one write
// port, hardwired reg0/reg1, optional write-through bypass, pending-write
// scoreboard and a sequential clear engine.
module param_register_bench
    import regbench_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      NREGS    = 32,
    parameter bit               BYPASS   = 1'b1,
    parameter bit               R1_CONST = 1'b1,
    parameter logic [WIDTH-1:0] R1_VALUE = WIDTH'(32'h8000_0001)
) (
    input logic                   clock,
    input logic                   reset_n,
    param_register_bench_if.slave bus
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] pend;
    logic             busy;
    logic             clearing;
    logic [AW-1:0]    clearIdx;
    logic             wrEn;
    logic             fwd1;
    logic             fwd2;
    logic             writeDropped;

    function automatic logic isWritable(input logic [AW-1:0] a);
        return (a != AW'(REG_ZERO)) && !(R1_CONST && (a == AW'(REG_CONST)));
    endfunction

    function automatic logic [WIDTH-1:0] storedValue(input logic [AW-1:0] a);
        if (a == AW'(REG_ZERO)) begin
            return '0;
        end else if (R1_CONST && (a == AW'(REG_CONST))) begin
            return R1_VALUE;
        end
        return regs[a];
    endfunction

    regbench_clear_fsm #(
        .NREGS(NREGS)
    ) u_clear (
        .clock    (clock),
        .reset_n  (reset_n),
        .clearReq (bus.clearReq),
        .busy     (busy),
        .clearDone(bus.clearDone),
        .clearing (clearing),
        .clearIdx (clearIdx)
    );

    // Writes to hardwired registers are folded into the enable so they
    // neither store, clear a pend bit nor get forwarded.
    assign wrEn = bus.cu_writeReg && !busy && isWritable(bus.writeAddy);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (clearing) begin
            if (isWritable(clearIdx)) begin
                regs[clearIdx] <= '0;
            end
        end else if (wrEn) begin
            regs[bus.writeAddy] <= bus.writeData;
        end
    end

    // Later assignments take priority: a reservation beats a same-cycle write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend <= '0;
        end else begin
            if (clearing && isWritable(clearIdx)) begin
                pend[clearIdx] <= 1'b0;
            end
            if (wrEn) begin
                pend[bus.writeAddy] <= 1'b0;
            end
            if (bus.cu_reserve && isWritable(bus.reserveAddy)) begin
                pend[bus.reserveAddy] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            writeDropped <= 1'b0;
        end else begin
            writeDropped <= bus.cu_writeReg && busy;
        end
    end

    assign fwd1 = BYPASS && wrEn && (bus.writeAddy == bus.readAddy1);
    assign fwd2 = BYPASS && wrEn && (bus.writeAddy == bus.readAddy2);

    assign bus.data1        = fwd1 ? bus.writeData : storedValue(bus.readAddy1);
    assign bus.data2        = fwd2 ? bus.writeData : storedValue(bus.readAddy2);
    assign bus.data3        = storedValue(bus.writeAddy);
    assign bus.pend1        = pend[bus.readAddy1];
    assign bus.pend2        = pend[bus.readAddy2];
    assign bus.busy         = busy;
    assign bus.writeDropped = writeDropped;

endmodule

// File: tb/tb_param_register_bench.sv
// Randomised bench for param_register_bench: a 32x32 and a 16x16 instance
// share one stimulus set and are checked against a cycle-level model.
module tb_param_register_bench;

    int tests = 0;
    int fails = 0;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        sel;
    logic [4:0]  ra1, ra2, wa, rsa;
    logic [31:0] wd;
    logic        we, rsv, clr;

    param_register_bench_if #(.WIDTH(32), .NREGS(32)) ifA ();
    param_register_bench_if #(.WIDTH(16), .NREGS(16)) ifB ();

    param_register_bench #(
        .WIDTH(32), .NREGS(32), .BYPASS(1'b1), .R1_CONST(1'b1), .R1_VALUE(32'h8000_0001)
    ) dutA (.clock(clock), .reset_n(reset_n), .bus(ifA));

    param_register_bench #(
        .WIDTH(16), .NREGS(16), .BYPASS(1'b1), .R1_CONST(1'b1), .R1_VALUE(16'h0001)
    ) dutB (.clock(clock), .reset_n(reset_n), .bus(ifB));

    assign ifA.readAddy1   = ra1;
    assign ifA.readAddy2   = ra2;
    assign ifA.writeAddy   = wa;
    assign ifA.reserveAddy = rsa;
    assign ifA.writeData   = wd;
    assign ifA.cu_writeReg = we && !sel;
    assign ifA.cu_reserve  = rsv && !sel;
    assign ifA.clearReq    = clr && !sel;

    assign ifB.readAddy1   = ra1[3:0];
    assign ifB.readAddy2   = ra2[3:0];
    assign ifB.writeAddy   = wa[3:0];
    assign ifB.reserveAddy = rsa[3:0];
    assign ifB.writeData   = wd[15:0];
    assign ifB.cu_writeReg = we && sel;
    assign ifB.cu_reserve  = rsv && sel;
    assign ifB.clearReq    = clr && sel;

    logic [31:0] d1, d2, d3;
    logic        p1, p2, bsy, cdone, wdrop;
    assign d1    = sel ? {16'h0, ifB.data1} : ifA.data1;
    assign d2    = sel ? {16'h0, ifB.data2} : ifA.data2;
    assign d3    = sel ? {16'h0, ifB.data3} : ifA.data3;
    assign p1    = sel ? ifB.pend1 : ifA.pend1;
    assign p2    = sel ? ifB.pend2 : ifA.pend2;
    assign bsy   = sel ? ifB.busy : ifA.busy;
    assign cdone = sel ? ifB.clearDone : ifA.clearDone;
    assign wdrop = sel ? ifB.writeDropped : ifA.writeDropped;

    // Reference model; phase counts cycles since clear start:
    // 0 idle, 1..n clearing register phase-1, n+1 done cycle.
    logic [31:0] mReg [32];
    logic [31:0] mPend;
    int          phase;
    logic        expDrop, expDone;

    function automatic int nRegs();
        return sel ? 16 : 32;
    endfunction

    function automatic logic [31:0] mask();
        return sel ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] r1Val();
        return sel ? 32'h0000_0001 : 32'h8000_0001;
    endfunction

    function automatic logic writable(input logic [4:0] a);
        return a >= 5'd2;
    endfunction

    function automatic logic [31:0] expRead(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (a == 5'd1) return r1Val();
        return mReg[a];
    endfunction

    function automatic logic [31:0] expPort(input logic [4:0] a);
        if (we && phase == 0 && writable(wa) && wa == a) return wd & mask();
        return expRead(a);
    endfunction

    function automatic logic expBusy();
        return phase != 0;
    endfunction

    function automatic logic [4:0] rndAddr();
        return 5'($urandom_range(0, nRegs() - 1));
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mReg[i] = 32'h0;
        mPend   = 32'h0;
        phase   = 0;
        expDrop = 1'b0;
        expDone = 1'b0;
    endtask

    task automatic idle();
        we = 1'b0; rsv = 1'b0; clr = 1'b0;
        ra1 = 5'd0; ra2 = 5'd0; wa = 5'd0; rsa = 5'd0; wd = 32'h0;
    endtask

    task automatic tick();
        int n;
        @(posedge clock);
        n       = nRegs();
        expDrop = we && phase != 0;
        expDone = (phase == n);
        if (phase == 0 && we && writable(wa)) begin
            mReg[wa]  = wd & mask();
            mPend[wa] = 1'b0;
        end
        if (phase >= 1 && phase <= n && writable(5'(phase - 1))) begin
            mReg[phase - 1]  = 32'h0;
            mPend[phase - 1] = 1'b0;
        end
        if (rsv && writable(rsa)) mPend[rsa] = 1'b1;
        if (phase == 0) phase = clr ? 1 : 0;
        else if (phase == n + 1) phase = 0;
        else phase++;
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        modelReset();
        #2;
        tests++; if (bsy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bsy); end
        tests++; if (cdone !== 1'b0) begin fails++; $display("FAIL reset_clearDone got=%b exp=0", cdone); end
        tests++; if (wdrop !== 1'b0) begin fails++; $display("FAIL reset_writeDropped got=%b exp=0", wdrop); end
        @(posedge clock); #1;
        reset_n = 1'b1;
        tick();
        for (int a = 0; a < nRegs(); a++) begin
            ra1 = 5'(a); ra2 = 5'(nRegs() - 1 - a); wa = 5'(a);
            #1;
            tests++; if (d1 !== ((a == 1) ? r1Val() : 32'h0)) begin fails++; $display("FAIL reset_data1 addr=%0d got=%h exp=%h", a, d1, (a == 1) ? r1Val() : 32'h0); end
            tests++; if (d2 !== expRead(ra2)) begin fails++; $display("FAIL reset_data2 addr=%0d got=%h exp=%h", ra2, d2, expRead(ra2)); end
            tests++; if (d3 !== expRead(wa)) begin fails++; $display("FAIL reset_data3 addr=%0d got=%h exp=%h", a, d3, expRead(wa)); end
            tests++; if (p1 !== 1'b0 || p2 !== 1'b0) begin fails++; $display("FAIL reset_pend addr=%0d got=%b%b exp=00", a, p1, p2); end
        end
        tests++; if (bsy !== 1'b0) begin fails++; $display("FAIL reset_busy_after got=%b exp=0", bsy); end
    endtask

    task automatic test_write_bypass();
        logic [31:0] v;
        idle();
        wa = 5'd5; wd = 32'hDEAD_BEEF; we = 1'b1; ra1 = 5'd5; ra2 = 5'd5;
        #1;
        tests++; if (d1 !== (32'hDEAD_BEEF & mask())) begin fails++; $display("FAIL bypass_data1 got=%h exp=%h", d1, 32'hDEAD_BEEF & mask()); end
        tests++; if (d2 !== (32'hDEAD_BEEF & mask())) begin fails++; $display("FAIL bypass_data2 got=%h exp=%h", d2, 32'hDEAD_BEEF & mask()); end
        tests++; if (d3 !== 32'h0) begin fails++; $display("FAIL bypass_data3_old got=%h exp=0", d3); end
        tick();
        we = 1'b0;
        #1;
        tests++; if (d3 !== (32'hDEAD_BEEF & mask())) begin fails++; $display("FAIL raw_data3 got=%h exp=%h", d3, 32'hDEAD_BEEF & mask()); end
        for (int i = 0; i < 24; i++) begin
            we = 1'b1; wa = rndAddr(); wd = $urandom;
            ra1 = ($urandom_range(0, 1) == 0) ? wa : rndAddr();
            ra2 = rndAddr();
            #1;
            v = expPort(ra1);
            tests++; if (d1 !== v) begin fails++; $display("FAIL wr_data1 addr=%0d got=%h exp=%h", ra1, d1, v); end
            tests++; if (d3 !== expRead(wa)) begin fails++; $display("FAIL wr_data3 addr=%0d got=%h exp=%h", wa, d3, expRead(wa)); end
            tick();
        end
        idle();
    endtask

    task automatic test_hardwired();
        idle();
        wa = 5'd0; wd = 32'hFFFF_FFFF; we = 1'b1; ra1 = 5'd0; ra2 = 5'd1;
        #1;
        tests++; if (d1 !== 32'h0) begin fails++; $display("FAIL hw_reg0_bypass got=%h exp=0", d1); end
        tick();
        wa = 5'd1; wd = 32'h0000_1234; ra1 = 5'd1;
        #1;
        tests++; if (d1 !== r1Val()) begin fails++; $display("FAIL hw_reg1_bypass got=%h exp=%h", d1, r1Val()); end
        tests++; if (d3 !== r1Val()) begin fails++; $display("FAIL hw_reg1_data3 got=%h exp=%h", d3, r1Val()); end
        tick();
        we = 1'b0; rsv = 1'b1; rsa = 5'd0;
        tick();
        rsa = 5'd1;
        tick();
        rsv = 1'b0; ra1 = 5'd0; ra2 = 5'd1;
        #1;
        tests++; if (d1 !== 32'h0) begin fails++; $display("FAIL hw_reg0_read got=%h exp=0", d1); end
        tests++; if (d2 !== r1Val()) begin fails++; $display("FAIL hw_reg1_read got=%h exp=%h", d2, r1Val()); end
        tests++; if (p1 !== 1'b0 || p2 !== 1'b0) begin fails++; $display("FAIL hw_pend got=%b%b exp=00", p1, p2); end
    endtask

    task automatic test_scoreboard();
        idle();
        rsv = 1'b1; rsa = 5'd7;
        tick();
        rsv = 1'b0; ra1 = 5'd7; ra2 = 5'd7;
        #1;
        tests++; if (p1 !== 1'b1) begin fails++; $display("FAIL sb_reserve got=%b exp=1", p1); end
        rsv = 1'b1; we = 1'b1; wa = 5'd7; wd = $urandom;
        tick();
        rsv = 1'b0; we = 1'b0;
        #1;
        tests++; if (p1 !== 1'b1) begin fails++; $display("FAIL sb_reserve_wins got=%b exp=1", p1); end
        we = 1'b1;
        tick();
        we = 1'b0;
        #1;
        tests++; if (p2 !== 1'b0) begin fails++; $display("FAIL sb_write_clears got=%b exp=0", p2); end
        for (int i = 0; i < 40; i++) begin
            rsv = 1'($urandom_range(0, 1)); rsa = 5'($urandom_range(0, 7));
            we  = 1'($urandom_range(0, 1)); wa  = 5'($urandom_range(0, 7)); wd = $urandom;
            tick();
            rsv = 1'b0; we = 1'b0;
            ra1 = 5'($urandom_range(0, 7)); ra2 = 5'($urandom_range(0, 7));
            #1;
            tests++; if (p1 !== mPend[ra1] || p2 !== mPend[ra2]) begin fails++; $display("FAIL sb_random a=%0d b=%0d got=%b%b exp=%b%b", ra1, ra2, p1, p2, mPend[ra1], mPend[ra2]); end
        end
        idle();
    endtask

    task automatic test_clear();
        int          k, busyCycles, doneAt, n;
        logic [31:0] fill9;
        n = nRegs();
        idle();
        for (int a = 2; a < n; a++) begin
            we = 1'b1; wa = 5'(a); wd = $urandom; rsv = 1'b1; rsa = 5'(a);
            if (a == 9) fill9 = wd & mask();
            tick();
        end
        idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        k = 1; busyCycles = 0; doneAt = -1;
        while (bsy === 1'b1 && k < 200) begin
            busyCycles++;
            if (cdone === 1'b1) doneAt = k;
            tests++; if (cdone !== expDone) begin fails++; $display("FAIL clr_done cycle=%0d got=%b exp=%b", k, cdone, expDone); end
            tests++; if (wdrop !== expDrop) begin fails++; $display("FAIL clr_dropped cycle=%0d got=%b exp=%b", k, wdrop, expDrop); end
            if (k == 6) begin
                tests++; if (wdrop !== 1'b1) begin fails++; $display("FAIL clr_drop_pulse got=%b exp=1", wdrop); end
                tests++; if (d3 !== fill9) begin fails++; $display("FAIL clr_drop_target got=%h exp=%h", d3, fill9); end
            end
            we = (k == 5); wa = 5'd9; wd = 32'hFFFF_FFFF; clr = (k == 3);
            ra1 = 5'd9; ra2 = rndAddr();
            #1;
            tests++; if (d1 !== expPort(ra1)) begin fails++; $display("FAIL clr_data1 cycle=%0d got=%h exp=%h", k, d1, expPort(ra1)); end
            tests++; if (p2 !== mPend[ra2]) begin fails++; $display("FAIL clr_pend2 cycle=%0d got=%b exp=%b", k, p2, mPend[ra2]); end
            tick();
            k++;
        end
        idle();
        tests++; if (busyCycles != n + 1) begin fails++; $display("FAIL clr_busy_len got=%0d exp=%0d", busyCycles, n + 1); end
        tests++; if (doneAt != n + 1) begin fails++; $display("FAIL clr_done_at got=%0d exp=%0d", doneAt, n + 1); end
        tests++; if (cdone !== 1'b0) begin fails++; $display("FAIL clr_done_single got=%b exp=0", cdone); end
        for (int a = 0; a < n; a++) begin
            ra1 = 5'(a); ra2 = 5'(a);
            #1;
            tests++; if (d1 !== ((a == 1) ? r1Val() : 32'h0)) begin fails++; $display("FAIL clr_result addr=%0d got=%h exp=%h", a, d1, (a == 1) ? r1Val() : 32'h0); end
            tests++; if (p2 !== 1'b0) begin fails++; $display("FAIL clr_pend addr=%0d got=%b exp=0", a, p2); end
        end
    endtask

    task automatic test_clear_abort();
        int n;
        n = nRegs();
        idle();
        we = 1'b1; wa = 5'(n - 1); wd = 32'hA5A5_5A5A;
        tick();
        rsv = 1'b1; rsa = 5'(n - 1); we = 1'b0;
        tick();
        idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        ra1 = 5'(n - 1);
        #1;
        tests++; if (d1 !== (32'hA5A5_5A5A & mask())) begin fails++; $display("FAIL abort_pre got=%h exp=%h", d1, 32'hA5A5_5A5A & mask()); end
        reset_n = 1'b0;
        modelReset();
        #1;
        tests++; if (bsy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", bsy); end
        tests++; if (d1 !== 32'h0 || p1 !== 1'b0) begin fails++; $display("FAIL abort_state got=%h/%b exp=0/0", d1, p1); end
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int i = 0; i < n + 4; i++) begin
            tick();
            tests++; if (cdone !== 1'b0 || bsy !== 1'b0) begin fails++; $display("FAIL abort_no_done cycle=%0d got=%b%b exp=00", i, cdone, bsy); end
        end
    endtask

    task automatic test_random();
        idle();
        for (int i = 0; i < 300; i++) begin
            tests++; if (bsy !== expBusy() || cdone !== expDone || wdrop !== expDrop) begin
                fails++; $display("FAIL rnd_status cycle=%0d got=%b%b%b exp=%b%b%b", i, bsy, cdone, wdrop, expBusy(), expDone, expDrop);
            end
            we  = 1'($urandom_range(0, 1)); wa = rndAddr(); wd = $urandom;
            rsv = ($urandom_range(0, 3) == 0); rsa = rndAddr();
            clr = ($urandom_range(0, 63) == 0);
            ra1 = ($urandom_range(0, 3) == 0) ? wa : rndAddr();
            ra2 = ($urandom_range(0, 3) == 0) ? wa : rndAddr();
            #1;
            tests++; if (d1 !== expPort(ra1) || d2 !== expPort(ra2) || d3 !== expRead(wa)) begin
                fails++; $display("FAIL rnd_data cycle=%0d got=%h %h %h exp=%h %h %h", i, d1, d2, d3, expPort(ra1), expPort(ra2), expRead(wa));
            end
            tests++; if (p1 !== mPend[ra1] || p2 !== mPend[ra2]) begin
                fails++; $display("FAIL rnd_pend cycle=%0d got=%b%b exp=%b%b", i, p1, p2, mPend[ra1], mPend[ra2]);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0;
        idle();
        reset_n = 1'b0;
        modelReset();
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            test_reset();
            test_write_bypass();
            test_hardwired();
            test_scoreboard();
            test_clear();
            test_clear_abort();
            test_random();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
